// File: rtl/writeback_regfile_pkg.sv
// Shared encodings for the writeback stage: bubble IR, datum/R7 source selects,
// CCR bit positions and the PC register index.
package writeback_regfile_pkg;

  localparam logic [15:0] NOP_IR = 16'hF000;

  // GPR writeback datum select
  typedef enum logic [1:0] {
    RWSEL_ALU   = 2'b00,
    RWSEL_MEM   = 2'b01,
    RWSEL_IMM   = 2'b10,
    RWSEL_PCINC = 2'b11
  } rwsel_e;

  // R7 source select; 101..111 are reserved and leave R7 unchanged
  typedef enum logic [2:0] {
    R7SEL_PCINC  = 3'b000,
    R7SEL_PCIMM  = 3'b001,
    R7SEL_ALU    = 3'b010,
    R7SEL_MEM    = 3'b011,
    R7SEL_RFOUT2 = 3'b100
  } r7sel_e;

  // CCR layout {C,Z}
  localparam int CCR_C = 1;
  localparam int CCR_Z = 0;

  // R7 doubles as the program counter
  localparam logic [2:0] PC_REG = 3'd7;

endpackage

// File: rtl/writeback_regfile_if.sv
// Stage-5 writeback bus: pipeline-register fields in, architectural state,
// decode read ports and forwarding info out.
interface writeback_regfile_if #(
  parameter int CNT_W = 32
);

  logic [15:0]      wb_ir;
  logic             wb_write_rf;
  logic [2:0]       wb_write_add;
  logic [1:0]       wb_reg_sel;
  logic             wb_write_r7;
  logic [2:0]       wb_r7_sel;
  logic [1:0]       wb_ccr;
  logic             wb_ccr_write;
  logic [15:0]      wb_alu_out;
  logic [15:0]      wb_mem_data;
  logic [15:0]      wb_imm970s;
  logic [15:0]      wb_pc_inc;
  logic [15:0]      wb_pc_imm_inc;
  logic [15:0]      wb_rf_out2;
  logic             pc_write;
  logic [15:0]      pc_in;
  logic [2:0]       rd_addr1;
  logic [2:0]       rd_addr2;
  logic [15:0]      rd_data1;
  logic [15:0]      rd_data2;
  logic [15:0]      pc_out;
  logic [1:0]       ccr_out;
  logic             fwd_valid;
  logic [2:0]       fwd_addr;
  logic [15:0]      fwd_data;
  logic [CNT_W-1:0] retired;

  // Pipeline / decode side driving the stage
  modport master (
    output wb_ir, wb_write_rf, wb_write_add, wb_reg_sel, wb_write_r7, wb_r7_sel,
           wb_ccr, wb_ccr_write, wb_alu_out, wb_mem_data, wb_imm970s, wb_pc_inc,
           wb_pc_imm_inc, wb_rf_out2, pc_write, pc_in, rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, pc_out, ccr_out, fwd_valid, fwd_addr, fwd_data, retired
  );

  // Writeback stage itself
  modport slave (
    input  wb_ir, wb_write_rf, wb_write_add, wb_reg_sel, wb_write_r7, wb_r7_sel,
           wb_ccr, wb_ccr_write, wb_alu_out, wb_mem_data, wb_imm970s, wb_pc_inc,
           wb_pc_imm_inc, wb_rf_out2, pc_write, pc_in, rd_addr1, rd_addr2,
    output rd_data1, rd_data2, pc_out, ccr_out, fwd_valid, fwd_addr, fwd_data, retired
  );

endinterface

// File: rtl/writeback_regfile_rf.sv
// 8x16 register file: one GPR write port for R0-R6, a dedicated R7 (PC) write
// port, and two combinational read ports that see pending writes.
module regfile_8x16
  import writeback_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        gprWe,
  input  logic [2:0]  gprAddr,
  input  logic [15:0] gprData,
  input  logic        r7We,
  input  logic [15:0] r7Data,
  input  logic [2:0]  rdAddr1,
  input  logic [2:0]  rdAddr2,
  output logic [15:0] rdData1,
  output logic [15:0] rdData2,
  output logic [15:0] r7Out
);

  logic [15:0] regs [8];

  // Register storage; R7 is only ever written through its own port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: every entry is reset on purpose -- the architecture defines all
      // eight registers (including the PC) as zero after reset, so this array
      // stays in flops rather than mapping to a RAM macro.
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      // NOTE: non-blocking updates so both ports see pre-edge values and the
      // result does not depend on statement order.
      if (gprWe && gprAddr != PC_REG) regs[gprAddr] <= gprData;
      if (r7We) regs[PC_REG] <= r7Data;
    end
  end

  // Read port 1 with write-through of this cycle's pending write
  always_comb begin
    rdData1 = regs[rdAddr1];
    if (rdAddr1 == PC_REG) begin
      if (r7We) rdData1 = r7Data;
    end else if (gprWe && rdAddr1 == gprAddr) begin
      rdData1 = gprData;
    end
  end

  // Read port 2 with write-through of this cycle's pending write
  always_comb begin
    rdData2 = regs[rdAddr2];
    if (rdAddr2 == PC_REG) begin
      if (r7We) rdData2 = r7Data;
    end else if (gprWe && rdAddr2 == gprAddr) begin
      rdData2 = gprData;
    end
  end

  assign r7Out = regs[PC_REG];

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: selects the writeback datum, arbitrates R7 sources, holds
// the CCR and retired-instruction counter, and exports forwarding info.
module writeback_regfile #(
  parameter logic [15:0] NOP_IR = writeback_regfile_pkg::NOP_IR,
  parameter int          CNT_W  = 32
) (
  input logic               clk,
  input logic               reset,
  writeback_regfile_if.slave bus
);

  import writeback_regfile_pkg::*;

  logic             bubble;
  logic             gprWe;
  logic             gprLowWe;
  logic [15:0]      wbData;
  logic             r7We;
  logic [15:0]      r7Data;
  logic [15:0]      r7Out;
  logic [1:0]       ccrQ;
  logic [CNT_W-1:0] retiredQ;

  assign bubble   = (bus.wb_ir == NOP_IR);
  assign gprWe    = bus.wb_write_rf & ~bubble;
  // R7 destinations go through the R7 arbitration instead of the GPR port
  assign gprLowWe = gprWe && (bus.wb_write_add != PC_REG);

  // Writeback datum select
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    wbData = bus.wb_alu_out;
    case (bus.wb_reg_sel)
      RWSEL_ALU:   wbData = bus.wb_alu_out;
      RWSEL_MEM:   wbData = bus.wb_mem_data;
      RWSEL_IMM:   wbData = bus.wb_imm970s;
      RWSEL_PCINC: wbData = bus.wb_pc_inc;
      default:     wbData = bus.wb_alu_out;
    endcase
  end

  // R7 priority: explicit writeback R7 update, then GPR write to R7, then fetch PC
  always_comb begin
    r7We   = 1'b0;
    r7Data = bus.pc_in;
    if (bus.wb_write_r7 && !bubble) begin
      r7We = 1'b1;
      case (bus.wb_r7_sel)
        R7SEL_PCINC:  r7Data = bus.wb_pc_inc;
        R7SEL_PCIMM:  r7Data = bus.wb_pc_imm_inc;
        R7SEL_ALU:    r7Data = bus.wb_alu_out;
        R7SEL_MEM:    r7Data = bus.wb_mem_data;
        R7SEL_RFOUT2: r7Data = bus.wb_rf_out2;
        // Reserved selects still win arbitration but leave R7 unchanged
        default:      r7We   = 1'b0;
      endcase
    end else if (gprWe && bus.wb_write_add == PC_REG) begin
      r7We   = 1'b1;
      r7Data = wbData;
    end else if (bus.pc_write) begin
      r7We   = 1'b1;
      r7Data = bus.pc_in;
    end
  end

  // Condition-code register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ccrQ <= 2'b00;
    else if (bus.wb_ccr_write && !bubble) ccrQ <= bus.wb_ccr;
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retiredQ <= '0;
    else if (!bubble) retiredQ <= retiredQ + CNT_W'(1);
  end

  regfile_8x16 u_rf (
    .clk     (clk),
    .reset   (reset),
    .gprWe   (gprLowWe),
    .gprAddr (bus.wb_write_add),
    .gprData (wbData),
    .r7We    (r7We),
    .r7Data  (r7Data),
    .rdAddr1 (bus.rd_addr1),
    .rdAddr2 (bus.rd_addr2),
    .rdData1 (bus.rd_data1),
    .rdData2 (bus.rd_data2),
    .r7Out   (r7Out)
  );

  assign bus.pc_out    = r7Out;
  assign bus.ccr_out   = ccrQ;
  assign bus.retired   = retiredQ;
  assign bus.fwd_valid = gprWe;
  assign bus.fwd_addr  = bus.wb_write_add;
  assign bus.fwd_data  = wbData;

endmodule
